rr_grant_controller: RTL and testbench

- Round-robin arbiter controller that shares one downstream resource among WIDTH requesters.
- Keeps a one-hot rotating priority pointer internally.
- Issues a registered one-hot grant and holds it until the resource signals completion.
- Rotates priority past the last grantee so every requester gets fair access; sits between requester ports and the shared resource's start/done handshake.

---
 rtl/rr_grant_controller.sv | 155 +++++++++++++++
 tb/tb_rr_grant_controller.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/rr_grant_controller.sv
// rtl/rr_grant_controller.sv - round-robin grant controller with start/done hold and GAP bubble
// Optional forced release on grant timeout: define RR_TIMEOUT_EN.
module rr_grant_controller #(
    parameter int WIDTH   = 4,
    parameter int TIMEOUT = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [WIDTH-1:0]         req,
    input  logic                     done,
    output logic [WIDTH-1:0]         gnt,
    output logic                     gnt_valid,
    output logic [$clog2(WIDTH)-1:0] gnt_id,
    output logic                     busy,
    output logic                     timeout_err
);

    localparam int IW = $clog2(WIDTH);

    generate
        if (WIDTH < 2 || TIMEOUT < 2) begin : g_bad_param
            $error("rr_grant_controller: WIDTH and TIMEOUT must both be >= 2");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next_state;
    logic [WIDTH-1:0] r_ptr;
    logic [WIDTH-1:0] r_gnt;
    logic [IW-1:0]    r_gnt_id;
    logic             r_timeout_err;
    logic             w_busy;

    logic [WIDTH-1:0] w_low_mask;
    logic [WIDTH-1:0] w_masked;
    logic [WIDTH-1:0] w_pick_src;
    logic [WIDTH-1:0] w_winner;
    logic [IW-1:0]    w_winner_id;
    logic             w_abort;
    logic             w_force;
    logic             w_release;

    // Bits at or above ptr win first; fall back to the whole vector to wrap around.
    assign w_low_mask = r_ptr - {{(WIDTH-1){1'b0}}, 1'b1};
    assign w_masked   = req & ~w_low_mask;
    assign w_pick_src = (|w_masked) ? w_masked : req;
    assign w_winner   = w_pick_src & (~w_pick_src + {{(WIDTH-1){1'b0}}, 1'b1});

    always_comb begin
        w_winner_id = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (w_winner[i]) begin
                w_winner_id = IW'(i);
            end
        end
    end

    assign w_abort = ~|(req & r_gnt);

`ifdef RR_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT) + 1;

    logic [CW-1:0] r_cnt;
    logic          w_to_hit;

    assign w_to_hit = (r_cnt == CW'(TIMEOUT - 1));
    assign w_force  = w_to_hit & ~done;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (r_state == ST_IDLE && |req) begin
            r_cnt <= '0;
        end else if (r_state == ST_BUSY) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end
`else
    assign w_force = 1'b0;
`endif

    assign w_release = done | w_abort | w_force;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: if (|req)     w_next_state = ST_BUSY;
            ST_BUSY: if (w_release) w_next_state = ST_GAP;
            ST_GAP:                w_next_state = ST_IDLE;
            default:               w_next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        w_busy = 1'b0;
        case (r_state)
            ST_BUSY: w_busy = 1'b1;
            ST_GAP:  w_busy = 1'b1;
            default: w_busy = 1'b0;
        endcase
    end

    // Pointer moves only on release, to one past the grantee.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_gnt         <= '0;
            r_gnt_id      <= '0;
            r_ptr         <= {{(WIDTH-1){1'b0}}, 1'b1};
            r_timeout_err <= 1'b0;
        end else begin
            r_timeout_err <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (|req) begin
                        r_gnt    <= w_winner;
                        r_gnt_id <= w_winner_id;
                    end
                end
                ST_BUSY: begin
                    if (w_release) begin
                        r_gnt         <= '0;
                        r_gnt_id      <= '0;
                        r_ptr         <= {r_gnt[WIDTH-2:0], r_gnt[WIDTH-1]};
                        r_timeout_err <= w_force;
                    end
                end
                default: begin
                    r_gnt    <= '0;
                    r_gnt_id <= '0;
                end
            endcase
        end
    end

    assign gnt         = r_gnt;
    assign gnt_valid   = |r_gnt;
    assign gnt_id      = r_gnt_id;
    assign busy        = w_busy;
    assign timeout_err = r_timeout_err;

endmodule

// File: tb/tb_rr_grant_controller.sv
// tb/tb_rr_grant_controller.sv - scoreboard bench for rr_grant_controller (WIDTH=4, TIMEOUT=4)
module tb_rr_grant_controller;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req;
    logic       done;
    logic [3:0] gnt;
    logic       gnt_valid;
    logic [1:0] gnt_id;
    logic       busy;
    logic       timeout_err;

    int vectors = 0;
    int errors  = 0;
    logic [5:0] exp_q[$];
    logic       prev_valid = 1'b0;

    rr_grant_controller #(.WIDTH(4), .TIMEOUT(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .done        (done),
        .gnt         (gnt),
        .gnt_valid   (gnt_valid),
        .gnt_id      (gnt_id),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: each new grant pops one expected {gnt, gnt_id} entry.
    always @(negedge clk) begin
        if (rst) begin
            prev_valid <= 1'b0;
        end else begin
            if (gnt_valid && !prev_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_grant", {28'd0, gnt}, 32'd0);
                end else begin
                    logic [5:0] e;
                    e = exp_q.pop_front();
                    check("grant_gnt", {28'd0, gnt}, {28'd0, e[5:2]});
                    check("grant_id", {30'd0, gnt_id}, {30'd0, e[1:0]});
                    check("grant_busy", {31'd0, busy}, 32'd1);
                end
            end
            prev_valid <= gnt_valid;
        end
    end

    task automatic wait_grant(input string name);
        bit seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (gnt_valid) begin
                seen = 1;
                break;
            end
        end
        if (!seen) check({name, "_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic pulse_done();
        done = 1'b1;
        @(negedge clk);
        done = 1'b0;
        check("release_gnt", {28'd0, gnt}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; req = 4'b0000; done = 1'b0;
        #12;
        check("reset_gnt", {28'd0, gnt}, 32'd0);
        check("reset_valid", {31'd0, gnt_valid}, 32'd0);
        check("reset_id", {30'd0, gnt_id}, 32'd0);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_terr", {31'd0, timeout_err}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Test 1: ptr=0001, req=0110 -> 0010 after one cycle
        req = 4'b0110;
        exp_q.push_back({4'b0010, 2'd1});
        @(negedge clk);
        check("t1_latency_gnt", {28'd0, gnt}, 32'h2);
        check("t1_busy", {31'd0, busy}, 32'd1);

        // Test 2: done -> GAP, IDLE, then 0100
        done = 1'b1;
        @(negedge clk);
        done = 1'b0;
        check("t2_gap_gnt", {28'd0, gnt}, 32'd0);
        check("t2_gap_busy", {31'd0, busy}, 32'd1);
        exp_q.push_back({4'b0100, 2'd2});
        @(negedge clk);
        check("t2_idle_gnt", {28'd0, gnt}, 32'd0);
        check("t2_idle_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        check("t2_regrant_gnt", {28'd0, gnt}, 32'h4);

        // Test 3: ptr=1000 after release, req=1010 -> 1000, then 0010
        req = 4'b1010;
        pulse_done();
        exp_q.push_back({4'b1000, 2'd3});
        wait_grant("t3_wrap_a");
        pulse_done();
        exp_q.push_back({4'b0010, 2'd1});
        wait_grant("t3_wrap_b");

        // Test 5b: async reset while gnt=0010
        #2 rst = 1'b1;
        #1;
        check("t5_rst_gnt", {28'd0, gnt}, 32'd0);
        check("t5_rst_busy", {31'd0, busy}, 32'd0);
        check("t5_rst_id", {30'd0, gnt_id}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Test 4: fairness from ptr=0001 with req=1111
        req = 4'b1111;
        exp_q.push_back({4'b0001, 2'd0});
        exp_q.push_back({4'b0010, 2'd1});
        exp_q.push_back({4'b0100, 2'd2});
        exp_q.push_back({4'b1000, 2'd3});
        exp_q.push_back({4'b0001, 2'd0});
        for (int k = 0; k < 5; k++) begin
            wait_grant("t4_fair");
            @(negedge clk);
            @(negedge clk);
            pulse_done();
        end

        // Test 5a: ptr=0010, grant 0100 then abort by dropping req[2]
        req = 4'b0100;
        exp_q.push_back({4'b0100, 2'd2});
        wait_grant("t5_abort_grant");
        req = 4'b0000;
        @(negedge clk);
        check("t5_abort_gnt", {28'd0, gnt}, 32'd0);
        check("t5_abort_terr", {31'd0, timeout_err}, 32'd0);
        check("t5_abort_busy", {31'd0, busy}, 32'd1);
        req = 4'b1111;
        exp_q.push_back({4'b1000, 2'd3});
        wait_grant("t5_ptr_check");
        pulse_done();
        req = 4'b0000;

`ifdef RR_TIMEOUT_EN
        // Test 6: forced release after TIMEOUT=4 busy cycles
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        req = 4'b0001;
        exp_q.push_back({4'b0001, 2'd0});
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("t6_hold_gnt", {28'd0, gnt}, 32'h1);
            check("t6_hold_terr", {31'd0, timeout_err}, 32'd0);
        end
        @(negedge clk);
        check("t6_to_gnt", {28'd0, gnt}, 32'd0);
        check("t6_to_terr", {31'd0, timeout_err}, 32'd1);
        req = 4'b0011;
        @(negedge clk);
        check("t6_terr_pulse", {31'd0, timeout_err}, 32'd0);
        exp_q.push_back({4'b0010, 2'd1});
        wait_grant("t6_ptr_grant");
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        done = 1'b1;
        @(negedge clk);
        done = 1'b0;
        check("t6_done_gnt", {28'd0, gnt}, 32'd0);
        check("t6_done_terr", {31'd0, timeout_err}, 32'd0);
        req = 4'b0000;
`endif

        repeat (4) @(negedge clk);
        check("queue_drained", exp_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
